// File: rtl/sbox_share_arbiter.sv
// sbox_share_arbiter
//   Shares one AES S-box between a datapath requester and a key-schedule
//   requester. A granted 32-bit word is substituted one byte per cycle. The
//   result is then held on rsp_data until rsp_ready is seen.
//
// Parameter
//   RR            1 = round-robin between the two requesters on a tie,
//                 0 = key-schedule port always wins
//
// Ports
//   clk, rst                    single clock, synchronous active-high reset
//   dp_valid/dp_ready           datapath request handshake
//   dp_word[31:0], dp_inverse   datapath column (byte k = [8k+7:8k]), 1 = InvSubBytes
//   ks_valid/ks_ready           key-schedule SubWord request (always forward S-box)
//   ks_word[31:0]               key-schedule word, same byte order
//   rsp_data[31:0]              substituted word of the current owner
//   rsp_dp_valid/rsp_ks_valid   response valid, routed to the owner
//   rsp_ready                   response accept, shared by both owners
//
// Build option
//   SBOX_SHARE_PIPE_EN  registers the S-box input byte. RUN then takes one
//                       fill cycle plus four write cycles.

module sbox_share_sbox (
   input  logic       inverse,
   input  logic [7:0] din,
   output logic [7:0] dout
);
   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0, as AES requires)
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] affine_fwd(input logic [7:0] a);
      return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] affine_inv(input logic [7:0] a);
      return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
   endfunction

   assign dout = inverse ? gf_inv(affine_inv(din)) : affine_fwd(gf_inv(din));
endmodule

module sbox_share_arbiter #(
   parameter int unsigned RR = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dp_valid,
   output logic        dp_ready,
   input  logic [31:0] dp_word,
   input  logic        dp_inverse,
   input  logic        ks_valid,
   output logic        ks_ready,
   input  logic [31:0] ks_word,
   output logic [31:0] rsp_data,
   output logic        rsp_dp_valid,
   output logic        rsp_ks_valid,
   input  logic        rsp_ready
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] word_q, word_d;
   logic        inv_q, inv_d;
   logic        owner_ks_q, owner_ks_d;
   logic        last_ks_q, last_ks_d;   // 1 = key schedule was served last
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        grant_ks, grant_dp, accept;
   logic        write_en, last_write;
   logic [7:0]  sbox_in, sbox_out;

`ifdef SBOX_SHARE_PIPE_EN
   logic        fill_q, fill_d;
   logic [7:0]  sbox_in_q, sbox_in_d;
   logic [1:0]  fetch_idx;
`endif

   sbox_share_sbox u_sbox (
      .inverse (inv_q),
      .din     (sbox_in),
      .dout    (sbox_out)
   );

   // Grant: ks wins a tie unless round-robin says it was served last
   always_comb begin
      grant_ks = 1'b0;
      grant_dp = 1'b0;
      if (ks_valid && (!dp_valid || RR == 0 || !last_ks_q)) grant_ks = 1'b1;
      else if (dp_valid)                                    grant_dp = 1'b1;
   end

   assign accept = dp_ready || ks_ready;

`ifdef SBOX_SHARE_PIPE_EN
   // First RUN cycle only loads byte 0 into the input register
   assign write_en   = (state_q == S_RUN) && !fill_q;
   assign fetch_idx  = fill_q ? 2'd0 : cnt_q + 2'd1;
   assign sbox_in    = sbox_in_q;
   always_comb begin
      sbox_in_d = sbox_in_q;
      fill_d    = fill_q;
      if (accept)              fill_d = 1'b1;
      if (state_q == S_RUN) begin
         fill_d    = 1'b0;
         sbox_in_d = word_q[{fetch_idx, 3'b000} +: 8];
      end
   end
`else
   assign write_en   = (state_q == S_RUN);
   assign sbox_in    = word_q[{cnt_q, 3'b000} +: 8];
`endif

   assign last_write = write_en && (cnt_q == 2'd3);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 2'd0;
         rsp_data_q <= 32'h0;
         last_ks_q  <= 1'b0;
         owner_ks_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rsp_data_q <= rsp_data_d;
         last_ks_q  <= last_ks_d;
         owner_ks_q <= owner_ks_d;
      end
   end

   // Latched request copy needs no reset; it is reloaded on every accept
   always_ff @(posedge clk) begin
      word_q <= word_d;
      inv_q  <= inv_d;
`ifdef SBOX_SHARE_PIPE_EN
      fill_q    <= fill_d;
      sbox_in_q <= sbox_in_d;
`endif
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept)     state_d = S_RUN;
         S_RUN:   if (last_write) state_d = S_DONE;
         S_DONE:  if (rsp_ready)  state_d = S_IDLE;
         default:                 state_d = S_IDLE;
      endcase
   end

   // Datapath and bookkeeping
   always_comb begin
      word_d     = word_q;
      inv_d      = inv_q;
      owner_ks_d = owner_ks_q;
      last_ks_d  = last_ks_q;
      cnt_d      = cnt_q;
      rsp_data_d = rsp_data_q;
      if (accept) begin
         word_d     = ks_ready ? ks_word : dp_word;
         inv_d      = ks_ready ? 1'b0 : dp_inverse;
         owner_ks_d = ks_ready;
         cnt_d      = 2'd0;
      end
      if (write_en) begin
         rsp_data_d[{cnt_q, 3'b000} +: 8] = sbox_out;
         cnt_d = cnt_q + 2'd1;   // wraps to 0 after byte 3
      end
      if (state_q == S_DONE && rsp_ready) last_ks_d = owner_ks_q;
   end

   // Outputs
   always_comb begin
      dp_ready     = 1'b0;
      ks_ready     = 1'b0;
      rsp_dp_valid = 1'b0;
      rsp_ks_valid = 1'b0;
      if (state_q == S_IDLE && !rst) begin
         dp_ready = grant_dp;
         ks_ready = grant_ks;
      end
      if (state_q == S_DONE) begin
         rsp_ks_valid = owner_ks_q;
         rsp_dp_valid = !owner_ks_q;
      end
   end

   assign rsp_data = rsp_data_q;
endmodule

// File: tb/tb_sbox_share_arbiter.sv
module tb_sbox_share_arbiter;
`ifdef SBOX_SHARE_PIPE_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 4;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        dp_valid, dp_ready, dp_inverse;
   logic [31:0] dp_word;
   logic        ks_valid, ks_ready;
   logic [31:0] ks_word;
   logic [31:0] rsp_data;
   logic        rsp_dp_valid, rsp_ks_valid, rsp_ready;
   // second instance (fixed priority)
   logic        dp_valid_b, dp_ready_b, ks_valid_b, ks_ready_b;
   logic [31:0] rsp_data_b;
   logic        rsp_dp_valid_b, rsp_ks_valid_b, rsp_ready_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sbox_share_arbiter #(.RR(1)) u_rr (
      .clk(clk), .rst(rst),
      .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_word(dp_word), .dp_inverse(dp_inverse),
      .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_word(ks_word),
      .rsp_data(rsp_data), .rsp_dp_valid(rsp_dp_valid), .rsp_ks_valid(rsp_ks_valid),
      .rsp_ready(rsp_ready)
   );

   sbox_share_arbiter #(.RR(0)) u_fp (
      .clk(clk), .rst(rst),
      .dp_valid(dp_valid_b), .dp_ready(dp_ready_b), .dp_word(dp_word), .dp_inverse(dp_inverse),
      .ks_valid(ks_valid_b), .ks_ready(ks_ready_b), .ks_word(ks_word),
      .rsp_data(rsp_data_b), .rsp_dp_valid(rsp_dp_valid_b), .rsp_ks_valid(rsp_ks_valid_b),
      .rsp_ready(rsp_ready_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Issue one request on the RR instance and check latency, routing and data
   task automatic run_req(input bit is_ks, input logic [31:0] w, input bit inv,
                          input logic [31:0] exp, input string name);
      int lat;
      bit got;
      rsp_ready  = 1'b1;
      dp_valid   = !is_ks;
      ks_valid   = is_ks;
      dp_word    = w;
      ks_word    = w;
      dp_inverse = inv;
      #1;
      n_tests++;
      if ({ks_ready, dp_ready} !== {is_ks, !is_ks}) begin
         n_fail++;
         $display("FAIL %s_ready: ks/dp=%b%b expected %b%b", name, ks_ready, dp_ready, is_ks, !is_ks);
      end
      tick();
      // changes after acceptance must not matter
      dp_valid = 1'b0; ks_valid = 1'b0;
      dp_word = ~w; ks_word = ~w; dp_inverse = ~inv;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         if (rsp_dp_valid || rsp_ks_valid) got = 1'b1;
         else begin
            tick();
            lat++;
         end
      end
      n_tests++;
      if (lat !== LAT) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d expected %0d", name, lat, LAT);
      end
      n_tests++;
      if ({rsp_ks_valid, rsp_dp_valid} !== {is_ks, !is_ks}) begin
         n_fail++;
         $display("FAIL %s_route: ks/dp valid=%b%b expected %b%b", name, rsp_ks_valid, rsp_dp_valid, is_ks, !is_ks);
      end
      n_tests++;
      if (rsp_data !== exp) begin
         n_fail++;
         $display("FAIL %s_data: got %h expected %h", name, rsp_data, exp);
      end
      tick();
      n_tests++;
      if ({rsp_ks_valid, rsp_dp_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL %s_release: valids=%b%b expected 00", name, rsp_ks_valid, rsp_dp_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      dp_valid = 1'b1; ks_valid = 1'b1;
      tick();
      tick();
      n_tests++;
      if ({dp_ready, ks_ready} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_ready: dp/ks=%b%b expected 00", dp_ready, ks_ready);
      end
      n_tests++;
      if ({rsp_dp_valid, rsp_ks_valid} !== 2'b00 || rsp_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_rsp: valids=%b%b data=%h expected 00 00000000", rsp_dp_valid, rsp_ks_valid, rsp_data);
      end
      rst = 1'b0;
      #1;
      n_tests++;
      if ({ks_ready, dp_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_first_tie: ks/dp=%b%b expected 10", ks_ready, dp_ready);
      end
      dp_valid = 1'b0; ks_valid = 1'b0;
      tick();
   endtask

   task automatic test_substitution();
      run_req(1'b1, 32'h00000000, 1'b0, 32'h63636363, "ks_zero");
      run_req(1'b0, 32'h53CA0100, 1'b0, 32'hED747C63, "dp_fwd");
      run_req(1'b0, 32'hEDCA7C63, 1'b1, 32'h53100100, "dp_inv_a");
      run_req(1'b0, 32'hED747C63, 1'b1, 32'h53CA0100, "dp_inv_b");
      run_req(1'b1, 32'h03020100, 1'b1, 32'h7B777C63, "ks_forces_fwd");
   endtask

   task automatic test_arbitration();
      logic [3:0] ga, gb;
      int ta[4];
      int na, nb;
      bit both;
      do_reset();
      na = 0; nb = 0; ga = '0; gb = '0; both = 1'b0;
      ta = '{default: 0};
      dp_word = 32'h11223344; ks_word = 32'h00000000; dp_inverse = 1'b0;
      rsp_ready = 1'b1; rsp_ready_b = 1'b1;
      dp_valid = 1'b1; ks_valid = 1'b1; dp_valid_b = 1'b1; ks_valid_b = 1'b1;
      #1;
      for (int c = 0; c < 60 && (na < 4 || nb < 4); c++) begin
         if (dp_ready && ks_ready) both = 1'b1;
         if ((dp_ready || ks_ready) && na < 4) begin
            ga[na] = ks_ready;
            ta[na] = c;
            na++;
         end
         if ((dp_ready_b || ks_ready_b) && nb < 4) begin
            gb[nb] = ks_ready_b;
            nb++;
         end
         tick();
      end
      dp_valid = 1'b0; ks_valid = 1'b0; dp_valid_b = 1'b0; ks_valid_b = 1'b0;
      repeat (10) tick();
      n_tests++;
      if (na !== 4 || nb !== 4) begin
         n_fail++;
         $display("FAIL arb_count: rr=%0d fp=%0d expected 4 4", na, nb);
      end
      n_tests++;
      if (ga !== 4'b0101) begin
         n_fail++;
         $display("FAIL arb_rr_order: got %b expected 0101 (bit0 first, 1=ks)", ga);
      end
      n_tests++;
      if (gb !== 4'b1111) begin
         n_fail++;
         $display("FAIL arb_fixed_order: got %b expected 1111", gb);
      end
      n_tests++;
      if (ta[1] - ta[0] !== LAT + 2 || ta[3] - ta[2] !== LAT + 2) begin
         n_fail++;
         $display("FAIL arb_interval: got %0d,%0d expected %0d", ta[1] - ta[0], ta[3] - ta[2], LAT + 2);
      end
      n_tests++;
      if (both !== 1'b0) begin
         n_fail++;
         $display("FAIL arb_single_ready: both readys seen high");
      end
      n_tests++;
      if (rsp_data_b !== 32'h63636363 || rsp_ks_valid_b !== 1'b0) begin
         n_fail++;
         $display("FAIL arb_fixed_data: data=%h vld=%b expected 63636363 0", rsp_data_b, rsp_ks_valid_b);
      end
   endtask

   task automatic test_backpressure();
      int w;
      bit stable;
      rsp_ready = 1'b0;
      dp_valid = 1'b1; dp_word = 32'h53CA0100; dp_inverse = 1'b0;
      #1;
      tick();
      dp_valid = 1'b0;
      w = 0;
      while (!rsp_dp_valid && w < 20) begin
         tick();
         w++;
      end
      dp_valid = 1'b1; ks_valid = 1'b1;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (rsp_data !== 32'hED747C63 || rsp_dp_valid !== 1'b1 || rsp_ks_valid !== 1'b0 ||
             dp_ready !== 1'b0 || ks_ready !== 1'b0) stable = 1'b0;
      end
      n_tests++;
      if (!stable) begin
         n_fail++;
         $display("FAIL hold_stable: data=%h dpv=%b ksv=%b rdy=%b%b expected ED747C63 1 0 00",
                  rsp_data, rsp_dp_valid, rsp_ks_valid, dp_ready, ks_ready);
      end
      rsp_ready = 1'b1;
      #1;
      n_tests++;
      if ({dp_ready, ks_ready} !== 2'b00) begin
         n_fail++;
         $display("FAIL done_exit_ready: dp/ks=%b%b expected 00", dp_ready, ks_ready);
      end
      tick();
      n_tests++;
      if ({ks_ready, dp_ready, rsp_dp_valid} !== 3'b100) begin
         n_fail++;
         $display("FAIL after_dp_tie: ks/dp rdy, dpv=%b%b%b expected 100", ks_ready, dp_ready, rsp_dp_valid);
      end
      dp_valid = 1'b0; ks_valid = 1'b0;
      tick();
   endtask

   task automatic test_rst_mid_run();
      bit seen;
      rsp_ready = 1'b1;
      ks_valid = 1'b1; ks_word = 32'h03020100;
      #1;
      tick();
      ks_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      ks_valid = 1'b1;
      #1;
      n_tests++;
      if (ks_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ready: ks_ready=%b expected 0", ks_ready);
      end
      tick();
      rst = 1'b0;
      ks_valid = 1'b0;
      #1;
      n_tests++;
      if ({rsp_dp_valid, rsp_ks_valid} !== 2'b00 || rsp_data !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_abort: valids=%b%b data=%h expected 00 00000000", rsp_dp_valid, rsp_ks_valid, rsp_data);
      end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (rsp_dp_valid || rsp_ks_valid) seen = 1'b1;
      end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_no_rsp: response seen after abort");
      end
      run_req(1'b1, 32'h03020100, 1'b0, 32'h7B777C63, "after_rst");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      dp_valid = 1'b0; ks_valid = 1'b0; dp_inverse = 1'b0;
      dp_word = 32'h0; ks_word = 32'h0; rsp_ready = 1'b1;
      dp_valid_b = 1'b0; ks_valid_b = 1'b0; rsp_ready_b = 1'b1;
      test_reset();
      test_substitution();
      test_arbitration();
      test_backpressure();
      test_rst_mid_run();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
